game_ctrl: RTL and testbench

Top-level game controller sitting directly upstream of the dinosaur delegate. Conditions raw jump/duck buttons, runs the game-state FSM (idle/run/dead), and detects dino–obstacle pixel collisions from the renderers' grey masks. Its `gameState`, `jump` and `duck` outputs drive the delegate and obstacle logic, and its `score` feeds the score display.

---
 rtl/game_pkg.sv | 18 +
 rtl/game_ctrl_if.sv | 26 ++
 rtl/button_debounce.sv | 46 ++++
 rtl/game_ctrl.sv | 147 ++++++++++++++
 tb/tb_game_ctrl.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared game constants: state encodings used by the controller, dino delegate and
// obstacle blocks, plus score width and saturation limit.
package game_pkg;

   localparam logic [1:0] GS_IDLE = 2'b00;
   localparam logic [1:0] GS_RUN  = 2'b10;
   localparam logic [1:0] GS_DEAD = 2'b01;

   localparam int SCORE_W   = 14;
   localparam int SCORE_MAX = 9999;

   typedef enum logic [1:0] {
      ST_IDLE = GS_IDLE,
      ST_RUN  = GS_RUN,
      ST_DEAD = GS_DEAD
   } gameState_e;

endpackage

// File: rtl/game_ctrl_if.sv
// Controller-facing signal bundle: frame timing, raw buttons, pixel masks in;
// game state, conditioned buttons and score out.
interface game_ctrl_if;
   import game_pkg::*;

   logic               frameTick;
   logic               btnJump;
   logic               btnDuck;
   logic               dinoPixel;
   logic               obstaclePixel;
   logic [1:0]         gameState;
   logic               jump;
   logic               duck;
   logic [SCORE_W-1:0] score;

   modport master (
      output frameTick, btnJump, btnDuck, dinoPixel, obstaclePixel,
      input  gameState, jump, duck, score
   );

   modport slave (
      input  frameTick, btnJump, btnDuck, dinoPixel, obstaclePixel,
      output gameState, jump, duck, score
   );

endinterface

// File: rtl/button_debounce.sv
// Raw button conditioner: 2-flop synchronizer, stable-sample counter, registered
// level and a one-cycle pulse on an accepted rising edge.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst,
   input  logic btnRaw,
   output logic level,
   output logic rise
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_p0;
   logic             sync_p1;
   logic             accepted;
   logic [CNT_W-1:0] stableCnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0   <= 1'b0;
         sync_p1   <= 1'b0;
         accepted  <= 1'b0;
         stableCnt <= '0;
         level     <= 1'b0;
      end else begin
         sync_p0 <= btnRaw;
         sync_p1 <= sync_p0;
         level   <= accepted;
         // Counter only runs while the synchronized sample disagrees with the accepted level
         if (sync_p1 == accepted) begin
            stableCnt <= '0;
         end else if (stableCnt == CNT_LAST) begin
            accepted  <= sync_p1;
            stableCnt <= '0;
         end else begin
            stableCnt <= stableCnt + CNT_W'(1);
         end
      end
   end

   assign rise = accepted & ~level;

endmodule

// File: rtl/game_ctrl.sv
// Game controller: button conditioning, IDLE/RUN/DEAD state machine, collision latch
// and saturating score. Define GAME_CTRL_INVINCIBLE_EN to disable collisions.
module game_ctrl
   import game_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES  = 250000,
   parameter int DEAD_HOLD_FRAMES = 30
) (
   input logic        clk,
   input logic        rst,
   game_ctrl_if.slave io
);

   localparam int HOLD_W = (DEAD_HOLD_FRAMES < 1) ? 1 : $clog2(DEAD_HOLD_FRAMES + 1);
   localparam logic [HOLD_W-1:0]  HOLD_LIM  = HOLD_W'(DEAD_HOLD_FRAMES);
   localparam logic [SCORE_W-1:0] SCORE_LIM = SCORE_W'(SCORE_MAX);

   function automatic logic [SCORE_W-1:0] scoreSatInc(input logic [SCORE_W-1:0] v);
      return (v >= SCORE_LIM) ? SCORE_LIM : v + SCORE_W'(1);
   endfunction

   function automatic logic [HOLD_W-1:0] holdSatInc(input logic [HOLD_W-1:0] v);
      return (v >= HOLD_LIM) ? HOLD_LIM : v + HOLD_W'(1);
   endfunction

   gameState_e         state;
   gameState_e         stateNxt;
   logic               jumpLevel;
   logic               jumpRise;
   logic               duckLevel;
   logic               duckRise;
   logic               pressLatch;
   logic               hitLatch;
   logic               hitNow;
   logic               fromDead;
   logic [SCORE_W-1:0] score;
   logic [HOLD_W-1:0]  holdCnt;
   logic               scoreClr;
   logic               scoreInc;
   logic               holdClr;
   logic               holdInc;
   logic               autoSet;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uJump (
      .clk    (clk),
      .rst    (rst),
      .btnRaw (io.btnJump),
      .level  (jumpLevel),
      .rise   (jumpRise)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDuck (
      .clk    (clk),
      .rst    (rst),
      .btnRaw (io.btnDuck),
      .level  (duckLevel),
      .rise   (duckRise)
   );

`ifdef GAME_CTRL_INVINCIBLE_EN
   assign hitLatch = 1'b0;
   assign hitNow   = 1'b0;
`else
   logic pixelHit;
   assign pixelHit = io.dinoPixel & io.obstaclePixel & (state == ST_RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)               hitLatch <= 1'b0;
      else if (io.frameTick) hitLatch <= 1'b0;
      else if (pixelHit)     hitLatch <= 1'b1;
   end

   // A hit on the tick cycle itself still belongs to the frame that is ending
   assign hitNow = hitLatch | pixelHit;
`endif

   // Every tick either consumes or discards the pending press; a press landing on the tick survives
   always_ff @(posedge clk or posedge rst) begin
      if (rst)               pressLatch <= 1'b0;
      else if (io.frameTick) pressLatch <= jumpRise;
      else if (jumpRise)     pressLatch <= 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= stateNxt;
   end

   always_comb begin
      stateNxt = state;
      scoreClr = 1'b0;
      scoreInc = 1'b0;
      holdClr  = 1'b0;
      holdInc  = 1'b0;
      autoSet  = 1'b0;
      if (io.frameTick) begin
         unique case (state)
            ST_IDLE: begin
               if (fromDead || pressLatch) begin
                  stateNxt = ST_RUN;
                  scoreClr = 1'b1;
               end
            end
            ST_RUN: begin
               if (hitNow) begin
                  stateNxt = ST_DEAD;
                  holdClr  = 1'b1;
               end else begin
                  scoreInc = 1'b1;
               end
            end
            ST_DEAD: begin
               holdInc = 1'b1;
               if ((holdCnt == HOLD_LIM) && pressLatch) begin
                  stateNxt = ST_IDLE;
                  autoSet  = 1'b1;
               end
            end
            default: stateNxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         score    <= '0;
         holdCnt  <= '0;
         fromDead <= 1'b0;
      end else begin
         if (scoreClr)      score <= '0;
         else if (scoreInc) score <= scoreSatInc(score);
         if (holdClr)       holdCnt <= '0;
         else if (holdInc)  holdCnt <= holdSatInc(holdCnt);
         // Restart IDLE lasts exactly one frame so the delegate can re-ground the dino
         if (io.frameTick)  fromDead <= autoSet;
      end
   end

   assign io.gameState = state;
   assign io.jump      = jumpLevel;
   assign io.duck      = duckLevel & (state == ST_RUN);
   assign io.score     = score;

   logic unusedDuckRise;
   assign unusedDuckRise = duckRise;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with short debounce/hold; expectations are hand-derived.
// Covers the GAME_CTRL_INVINCIBLE_EN build when that macro is defined.
module tb_game_ctrl;
   import game_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   logic [1:0]  preTickState;
   logic [13:0] preTickScore;

   always #5 clk = ~clk;

   game_ctrl_if io();

   game_ctrl #(.DEBOUNCE_CYCLES(4), .DEAD_HOLD_FRAMES(2)) dut (
      .clk (clk),
      .rst (rst),
      .io  (io)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // One 100-cycle frame ending with the frameTick edge; returns where the tick result is visible
   task automatic frame(input bit pressJ, input bit hitMid, input bit hitTick);
      for (int c = 0; c < 100; c++) begin
         io.btnJump       = pressJ && (c >= 10) && (c < 20);
         io.dinoPixel     = (hitMid && c == 50) || (hitTick && c == 99);
         io.obstaclePixel = (hitMid && c == 50) || (hitTick && c == 99);
         io.frameTick     = (c == 99);
         if (c == 99) begin
            preTickState = io.gameState;
            preTickScore = io.score;
         end
         @(negedge clk);
      end
      io.frameTick     = 1'b0;
      io.dinoPixel     = 1'b0;
      io.obstaclePixel = 1'b0;
      io.btnJump       = 1'b0;
   endtask

   initial begin
      io.frameTick     = 1'b0;
      io.btnJump       = 1'b0;
      io.btnDuck       = 1'b0;
      io.dinoPixel     = 1'b0;
      io.obstaclePixel = 1'b0;
      step(3);
      check("rst_state", io.gameState, GS_IDLE);
      check("rst_score", io.score, 0);
      check("rst_jump", io.jump, 0);
      check("rst_duck", io.duck, 0);
      rst = 1'b0;
      step(2);

      // Glitch reject
      io.btnJump = 1'b1;
      step(3);
      io.btnJump = 1'b0;
      step(12);
      check("glitch_jump", io.jump, 0);
      check("glitch_state", io.gameState, GS_IDLE);

      // Held press: jump rises exactly 7 cycles after the raw rise
      io.btnJump = 1'b1;
      step(6);
      check("jump_lat6", io.jump, 0);
      step(1);
      check("jump_lat7", io.jump, 1);
      step(3);
      io.btnJump = 1'b0;
      step(10);
      check("jump_release", io.jump, 0);
      check("idle_before_tick", io.gameState, GS_IDLE);

      // Start
      frame(0, 0, 0);
      check("start_pre", preTickState, GS_IDLE);
      check("start_state", io.gameState, GS_RUN);
      check("start_score", io.score, 0);
      for (int f = 0; f < 5; f++) frame(0, 0, 0);
      check("run_score5", io.score, 5);
      check("run_state", io.gameState, GS_RUN);

`ifdef GAME_CTRL_INVINCIBLE_EN
      frame(0, 1, 0);
      check("inv_mid_state", io.gameState, GS_RUN);
      check("inv_mid_score", io.score, 6);
      frame(0, 0, 1);
      check("inv_tick_state", io.gameState, GS_RUN);
      check("inv_tick_score", io.score, 7);
      frame(0, 1, 1);
      check("inv_both_state", io.gameState, GS_RUN);
      check("inv_both_score", io.score, 8);
`else
      // Collision mid-frame
      frame(0, 1, 0);
      check("hit_pre", preTickState, GS_RUN);
      check("hit_state", io.gameState, GS_DEAD);
      check("hit_score", io.score, 5);

      // Restart sequence with duck held
      io.btnDuck = 1'b1;
      frame(1, 0, 0);
      check("dead_t1", io.gameState, GS_DEAD);
      check("dead_duck", io.duck, 0);
      frame(0, 0, 0);
      check("dead_t2", io.gameState, GS_DEAD);
      frame(0, 0, 0);
      check("dead_discard", io.gameState, GS_DEAD);
      check("dead_score", io.score, 5);
      frame(1, 0, 0);
      check("restart_idle", io.gameState, GS_IDLE);
      check("idle_score", io.score, 5);
      check("idle_duck", io.duck, 0);
      frame(0, 0, 0);
      check("auto_run", io.gameState, GS_RUN);
      check("auto_score", io.score, 0);
      check("run_duck", io.duck, 1);
      io.btnDuck = 1'b0;
      frame(0, 0, 0);
      check("duck_off", io.duck, 0);
      check("score_1", io.score, 1);

      // Collision on the tick cycle
      frame(0, 0, 1);
      check("tickhit_state", io.gameState, GS_DEAD);
      check("tickhit_score", io.score, 1);

      frame(0, 0, 0);
      frame(0, 0, 0);
      frame(1, 0, 0);
      check("restart2_idle", io.gameState, GS_IDLE);
      frame(0, 0, 0);
      check("restart2_run", io.gameState, GS_RUN);
`endif

      // Saturation: back-to-back ticks
      io.frameTick = 1'b1;
      step(9998);
      io.frameTick = 1'b0;
      step(1);
`ifdef GAME_CTRL_INVINCIBLE_EN
      check("sat_9998", io.score, 9999);
`else
      check("sat_9998", io.score, 9998);
`endif
      io.frameTick = 1'b1;
      step(3);
      io.frameTick = 1'b0;
      step(1);
      check("sat_9999", io.score, 9999);
      check("sat_state", io.gameState, GS_RUN);

      // Asynchronous reset mid-frame
      io.btnJump = 1'b1;
      io.btnDuck = 1'b1;
      step(10);
      check("pre_rst_jump", io.jump, 1);
      check("pre_rst_duck", io.duck, 1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_state", io.gameState, GS_IDLE);
      check("arst_score", io.score, 0);
      check("arst_jump", io.jump, 0);
      check("arst_duck", io.duck, 0);
      io.btnJump = 1'b0;
      io.btnDuck = 1'b0;
      step(2);
      rst = 1'b0;
      step(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
